pcie_tx_tlp_writer: RTL and testbench

Core-side transmitter for the PCIe AXI TX stream (s_axis_tx_*). It takes a command (MWr32 or MRd32) plus a first-word-fall-through data source and emits one complete 3DW-header TLP per command on the 32-bit AXI stream. It honours link-up, tx_buf_av credit gating and tready backpressure. It sits between the user DMA/control logic and the PCIe endpoint (or its simulation bridge).

---
 rtl/pcie_tx_tlp_writer_pkg.sv | 13 +
 rtl/pcie_tx_tlp_writer_hdr_builder.sv | 37 +++
 rtl/pcie_tx_tlp_writer.sv | 135 +++++++++++++
 tb/tb_pcie_tx_tlp_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tx_tlp_writer_pkg.sv
// pcie_tx_tlp_writer_pkg: shared TLP field constants, FSM states and header helper
package pcie_tx_tlp_writer_pkg;
    localparam int LEN_W = 10;
    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;
    localparam logic [3:0] BE_ALL         = 4'hF;
    localparam logic [3:0] BE_NONE        = 4'h0;
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_DATA} state_e;
    function automatic logic [31:0] tlp_dw0(input logic [1:0] fmt, input logic [LEN_W-1:0] len);
        return {1'b0, fmt, TYPE_MEM, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
    endfunction
endpackage

// File: rtl/pcie_tx_tlp_writer_hdr_builder.sv
// pcie_tx_tlp_writer_hdr_builder: captures the three 3DW header dwords when a command is accepted
module pcie_tx_tlp_writer_hdr_builder
    import pcie_tx_tlp_writer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_wr,
    input  logic [31:0]      i_addr,
    input  logic [LEN_W-1:0] i_len,
    input  logic [7:0]       i_tag,
    input  logic [7:0]       i_bus,
    input  logic [4:0]       i_dev,
    input  logic [2:0]       i_func,
    output logic [31:0]      o_dw0,
    output logic [31:0]      o_dw1,
    output logic [31:0]      o_dw2
);
    logic [31:0] dw0_q, dw1_q, dw2_q;

    // Header stays frozen for the whole TLP so stalled beats keep stable data
    always_ff @(posedge clk) begin
        if (rst) begin
            dw0_q <= '0;
            dw1_q <= '0;
            dw2_q <= '0;
        end else if (i_load) begin
            dw0_q <= tlp_dw0(i_wr ? FMT_3DW_DATA : FMT_3DW_NODATA, i_len);
            dw1_q <= {i_bus, i_dev, i_func, i_tag, (i_len == LEN_W'(1)) ? BE_NONE : BE_ALL, BE_ALL};
            dw2_q <= i_addr & 32'hFFFF_FFFC;
        end
    end

    assign o_dw0 = dw0_q;
    assign o_dw1 = dw1_q;
    assign o_dw2 = dw2_q;
endmodule

// File: rtl/pcie_tx_tlp_writer.sv
// pcie_tx_tlp_writer: turns MWr32/MRd32 commands into 3DW-header TLPs on a 32-bit AXI TX stream
module pcie_tx_tlp_writer
    import pcie_tx_tlp_writer_pkg::*;
#(
    parameter int MAX_WR_DWORDS    = 128,
    parameter int MAX_RD_DWORDS    = 128,
    parameter int BUF_AV_THRESHOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_lnk_up,
    input  logic [7:0]  i_cfg_bus_number,
    input  logic [4:0]  i_cfg_device_number,
    input  logic [2:0]  i_cfg_function_number,
    input  logic        i_cmd_stb,
    output logic        o_cmd_rdy,
    input  logic        i_cmd_wr,
    input  logic [31:0] i_cmd_addr,
    input  logic [9:0]  i_cmd_len,
    input  logic [7:0]  i_cmd_tag,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    output logic        o_data_rd,
    output logic [31:0] o_s_axis_tx_tdata,
    output logic [3:0]  o_s_axis_tx_tkeep,
    output logic [3:0]  o_s_axis_tx_tuser,
    output logic        o_s_axis_tx_tlast,
    output logic        o_s_axis_tx_tvalid,
    input  logic        i_s_axis_tx_tready,
    input  logic [5:0]  i_tx_buf_av,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err_len,
    output logic        o_abort
);
    localparam logic [LEN_W-1:0] MAX_WR = LEN_W'(MAX_WR_DWORDS);
    localparam logic [LEN_W-1:0] MAX_RD = LEN_W'(MAX_RD_DWORDS);
    localparam logic [5:0]       BUF_TH = 6'(BUF_AV_THRESHOLD);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             wr_q, rdy_q, done_q, done_d, err_q, abort_q, abort_d;
    logic             hs, len_ok, beat, in_hdr, in_data, last_data;
    logic [31:0]      dw0, dw1, dw2;

    assign hs        = i_cmd_stb & rdy_q;
    assign len_ok    = (i_cmd_len != '0) & (i_cmd_len <= (i_cmd_wr ? MAX_WR : MAX_RD));
    assign in_hdr    = (state_q == S_HDR0) | (state_q == S_HDR1) | (state_q == S_HDR2);
    assign in_data   = state_q == S_DATA;
    assign last_data = cnt_q == LEN_W'(1);

    pcie_tx_tlp_writer_hdr_builder u_hdr (
        .clk    (clk),
        .rst    (rst),
        .i_load (hs & len_ok),
        .i_wr   (i_cmd_wr),
        .i_addr (i_cmd_addr),
        .i_len  (i_cmd_len),
        .i_tag  (i_cmd_tag),
        .i_bus  (i_cfg_bus_number),
        .i_dev  (i_cfg_device_number),
        .i_func (i_cfg_function_number),
        .o_dw0  (dw0),
        .o_dw1  (dw1),
        .o_dw2  (dw2)
    );

    // A dropped link blocks any further beat or pop in the same cycle it is seen
    assign o_s_axis_tx_tvalid = i_lnk_up & (in_hdr | (in_data & i_data_valid));
    assign beat               = o_s_axis_tx_tvalid & i_s_axis_tx_tready;
    assign o_data_rd          = in_data & beat;
    assign o_s_axis_tx_tdata  = (state_q == S_HDR0) ? dw0 :
                                (state_q == S_HDR1) ? dw1 :
                                (state_q == S_HDR2) ? dw2 :
                                in_data ? i_data : 32'h0;
    assign o_s_axis_tx_tlast  = ((state_q == S_HDR2) & !wr_q) | (in_data & last_data);
    assign o_s_axis_tx_tkeep  = 4'hF;
    assign o_s_axis_tx_tuser  = 4'h0;
    assign o_busy             = state_q != S_IDLE;
    assign o_cmd_rdy          = rdy_q;
    assign o_done             = done_q;
    assign o_err_len          = err_q;
    assign o_abort            = abort_q;

    // Next state, payload countdown and completion/abort pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: if (hs && len_ok) begin
                state_d = S_HDR0;
                cnt_d   = i_cmd_len;
            end
            S_HDR0: state_d = beat ? S_HDR1 : S_HDR0;
            S_HDR1: state_d = beat ? S_HDR2 : S_HDR1;
            S_HDR2: if (beat) begin
                state_d = wr_q ? S_DATA : S_IDLE;
                done_d  = !wr_q;
            end
            S_DATA: if (beat) begin
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = last_data ? S_IDLE : S_DATA;
                done_d  = last_data;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !i_lnk_up) begin
            state_d = S_IDLE;
            abort_d = 1'b1;
        end
    end

    // State, latched command type and registered handshake/status strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hs) wr_q <= i_cmd_wr;
            rdy_q   <= (state_d == S_IDLE) & !hs & i_lnk_up & (i_tx_buf_av >= BUF_TH);
            done_q  <= done_d;
            err_q   <= hs & !len_ok;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_pcie_tx_tlp_writer.sv
// tb_pcie_tx_tlp_writer: randomized command traffic checked against a TLP-level reference model
module tb_pcie_tx_tlp_writer;
    logic        clk = 1'b0;
    logic        rst, i_lnk_up, i_cmd_stb, o_cmd_rdy, i_cmd_wr, i_data_valid, o_data_rd;
    logic [7:0]  i_cfg_bus_number, i_cmd_tag;
    logic [4:0]  i_cfg_device_number;
    logic [2:0]  i_cfg_function_number;
    logic [31:0] i_cmd_addr, i_data, o_s_axis_tx_tdata;
    logic [9:0]  i_cmd_len;
    logic [3:0]  o_s_axis_tx_tkeep, o_s_axis_tx_tuser;
    logic        o_s_axis_tx_tlast, o_s_axis_tx_tvalid, i_s_axis_tx_tready;
    logic [5:0]  i_tx_buf_av;
    logic        o_busy, o_done, o_err_len, o_abort;

    always #5 clk = ~clk;

    pcie_tx_tlp_writer dut (
        .clk(clk), .rst(rst), .i_lnk_up(i_lnk_up),
        .i_cfg_bus_number(i_cfg_bus_number), .i_cfg_device_number(i_cfg_device_number),
        .i_cfg_function_number(i_cfg_function_number),
        .i_cmd_stb(i_cmd_stb), .o_cmd_rdy(o_cmd_rdy), .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .i_cmd_tag(i_cmd_tag),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_rd(o_data_rd),
        .o_s_axis_tx_tdata(o_s_axis_tx_tdata), .o_s_axis_tx_tkeep(o_s_axis_tx_tkeep),
        .o_s_axis_tx_tuser(o_s_axis_tx_tuser), .o_s_axis_tx_tlast(o_s_axis_tx_tlast),
        .o_s_axis_tx_tvalid(o_s_axis_tx_tvalid), .i_s_axis_tx_tready(i_s_axis_tx_tready),
        .i_tx_buf_av(i_tx_buf_av), .o_busy(o_busy), .o_done(o_done),
        .o_err_len(o_err_len), .o_abort(o_abort)
    );

    int          n_checks = 0, n_errors = 0;
    logic [31:0] src_q[$], got_d[$], exp_d[$];
    bit          got_l[$], exp_l[$];
    int          pops, done_cnt, err_cnt, abort_cnt, rmode, cyc, drop_after;
    bit          gap_en, stall_chk, hs_seen, hs_prev, prev_stall, last_acc_prev, tv_seen, busy_seen;
    logic [31:0] prev_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic drive();
        cyc++;
        if (hs_seen) i_cmd_stb = 1'b0;
        if (drop_after > 0 && got_d.size() >= drop_after) i_lnk_up = 1'b0;
        i_s_axis_tx_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
        i_data_valid = src_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0);
        i_data = src_q.size() > 0 ? src_q[0] : 32'h0;
    endtask

    task automatic sample();
        bit acc;
        acc = o_s_axis_tx_tvalid && i_s_axis_tx_tready;
        if (stall_chk && prev_stall) begin
            check("stall_valid", o_s_axis_tx_tvalid, 1);
            check("stall_data", o_s_axis_tx_tdata, prev_data);
        end
        if (hs_prev && exp_d.size() > 0) begin
            check("dw0_valid", o_s_axis_tx_tvalid, 1);
            check("dw0_data", o_s_axis_tx_tdata, exp_d[0]);
        end
        if (!i_lnk_up && o_busy) begin
            check("lnk_down_tvalid", o_s_axis_tx_tvalid, 0);
            check("lnk_down_pop", o_data_rd, 0);
        end
        if (o_done) begin
            done_cnt++;
            check("done_after_last", last_acc_prev, 1);
        end
        if (o_err_len) err_cnt++;
        if (o_abort) begin
            abort_cnt++;
            check("abort_tvalid", o_s_axis_tx_tvalid, 0);
        end
        if (o_s_axis_tx_tvalid) tv_seen = 1'b1;
        if (o_busy) busy_seen = 1'b1;
        if (acc) begin
            got_d.push_back(o_s_axis_tx_tdata);
            got_l.push_back(o_s_axis_tx_tlast);
        end
        if (o_data_rd) begin
            pops++;
            check("pop_valid", i_data_valid, 1);
            if (src_q.size() > 0) void'(src_q.pop_front());
        end
        if (i_cmd_stb && o_cmd_rdy) hs_seen = 1'b1;
        hs_prev       = i_cmd_stb && o_cmd_rdy;
        prev_stall    = o_s_axis_tx_tvalid && !i_s_axis_tx_tready;
        prev_data     = o_s_axis_tx_tdata;
        last_acc_prev = acc && o_s_axis_tx_tlast;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_tvalid", o_s_axis_tx_tvalid, 0);
        check("rst_tdata", o_s_axis_tx_tdata, 0);
        check("rst_tlast", o_s_axis_tx_tlast, 0);
        check("rst_tkeep", o_s_axis_tx_tkeep, 4'hF);
        check("rst_tuser", o_s_axis_tx_tuser, 0);
        check("rst_busy", o_busy, 0);
        check("rst_rdy", o_cmd_rdy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err_len, 0);
        check("rst_abort", o_abort, 0);
        check("rst_pop", o_data_rd, 0);
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len, input logic [7:0] tag,
                           input logic [31:0] base, input int rm, input bit gap, input int drop);
        int full;
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete(); src_q.delete();
        pops = 0; done_cnt = 0; abort_cnt = 0; err_cnt = 0;
        rmode = rm; gap_en = gap; stall_chk = !gap && drop == 0; drop_after = drop;
        if (wr) for (int i = 0; i < len; i++) src_q.push_back(base != 0 ? base + 32'(i) : $urandom());
        exp_d.push_back(((wr ? 32'd2 : 32'd0) << 29) | 32'(len));
        exp_d.push_back((32'(i_cfg_bus_number) << 24) | (32'(i_cfg_device_number) << 19) |
                        (32'(i_cfg_function_number) << 16) | (32'(tag) << 8) |
                        ((len == 1 ? 32'h0 : 32'hF) << 4) | 32'hF);
        exp_d.push_back(addr & ~32'h3);
        if (wr) foreach (src_q[i]) exp_d.push_back(src_q[i]);
        full = exp_d.size();
        for (int i = 0; i < full; i++) exp_l.push_back(drop == 0 && i == full - 1);
        while (drop > 0 && exp_d.size() > drop) begin
            void'(exp_d.pop_back());
            void'(exp_l.pop_back());
        end
        i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_len = 10'(len); i_cmd_tag = tag;
        i_cmd_stb = 1'b1; hs_seen = 1'b0;
        for (int t = 0; t < 3000 && done_cnt == 0 && abort_cnt == 0; t++) cycle();
        repeat (2) cycle();
        check("end_done", done_cnt, drop > 0 ? 0 : 1);
        check("end_abort", abort_cnt, drop > 0 ? 1 : 0);
        check("beat_count", got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            check("beat_data", got_d[i], exp_d[i]);
            check("beat_last", got_l[i], exp_l[i]);
        end
        check("pops", pops, wr ? (drop > 0 ? drop - 3 : len) : 0);
        check("src_left", src_q.size(), (wr && drop > 0) ? len - (drop - 3) : 0);
        i_lnk_up = 1'b1; drop_after = 0; stall_chk = 1'b0; i_cmd_stb = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic err_cmd(input bit wr, input int len);
        exp_d.delete(); src_q.delete();
        err_cnt = 0; tv_seen = 1'b0; busy_seen = 1'b0; pops = 0; hs_seen = 1'b0;
        i_cmd_wr = wr; i_cmd_len = 10'(len); i_cmd_addr = 32'h6000; i_cmd_stb = 1'b1;
        for (int t = 0; t < 20 && !hs_seen; t++) cycle();
        i_cmd_stb = 1'b0;
        repeat (4) cycle();
        check("err_hs", hs_seen, 1);
        check("err_pulse", err_cnt, 1);
        check("err_no_tvalid", tv_seen, 0);
        check("err_no_busy", busy_seen, 0);
        check("err_no_pop", pops, 0);
    endtask

    initial begin
        rst = 1'b1; i_lnk_up = 1'b1; i_cmd_stb = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0;
        i_cmd_len = '0; i_cmd_tag = '0; i_data = '0; i_data_valid = 1'b0; i_s_axis_tx_tready = 1'b1;
        i_tx_buf_av = 6'd8; i_cfg_bus_number = 8'd0; i_cfg_device_number = 5'd0; i_cfg_function_number = 3'd1;
        rmode = 0; cyc = 0; drop_after = 0; gap_en = 1'b0; stall_chk = 1'b0; hs_seen = 1'b0;
        hs_prev = 1'b0; prev_stall = 1'b0; last_acc_prev = 1'b0; prev_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        repeat (2) cycle();
        check("rdy_idle", o_cmd_rdy, 1);
        run_cmd(1'b1, 32'h0000_1003, 4, 8'h05, 32'hA0, 0, 1'b0, 0);
        check("mwr_dw0_literal", got_d.size() > 0 ? got_d[0] : 32'hX, 32'h4000_0004);
        run_cmd(1'b0, 32'h0000_2004, 1, 8'h06, 32'h0, 0, 1'b0, 0);
        run_cmd(1'b1, 32'h0000_3000, 2, 8'h07, 32'hB0, 2, 1'b0, 0);
        i_tx_buf_av = 6'd1;
        repeat (2) cycle();
        i_cmd_wr = 1'b0; i_cmd_len = 10'd2; i_cmd_stb = 1'b1; hs_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("credit_rdy", o_cmd_rdy, 0);
            check("credit_tvalid", o_s_axis_tx_tvalid, 0);
        end
        i_cmd_stb = 1'b0;
        i_tx_buf_av = 6'd2;
        run_cmd(1'b0, 32'h0000_5000, 2, 8'h11, 32'h0, 0, 1'b0, 0);
        i_tx_buf_av = 6'd8;
        err_cmd(1'b1, 0);
        err_cmd(1'b1, 129);
        err_cmd(1'b0, 0);
        err_cmd(1'b0, 1023);
        run_cmd(1'b1, $urandom(), 128, 8'h21, 32'h0, 1, 1'b1, 0);
        run_cmd(1'b0, $urandom(), 128, 8'h22, 32'h0, 1, 1'b0, 0);
        run_cmd(1'b1, 32'h0000_4000, 8, 8'h09, 32'hC0, 0, 1'b0, 5);
        got_d.delete(); exp_d.delete(); src_q = {32'h1, 32'h2, 32'h3, 32'h4};
        rmode = 0; gap_en = 1'b0;
        i_cmd_wr = 1'b1; i_cmd_len = 10'd4; i_cmd_stb = 1'b1; hs_seen = 1'b0;
        for (int t = 0; t < 20 && got_d.size() < 2; t++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset();
        src_q.delete();
        repeat (3) cycle();
        repeat (25) begin
            i_cfg_bus_number = 8'($urandom());
            i_cfg_device_number = 5'($urandom());
            i_cfg_function_number = 3'($urandom());
            run_cmd(1'($urandom_range(0, 1)), $urandom(), $urandom_range(1, 16), 8'($urandom()),
                    32'h0, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
